// File: rtl/mod47_horner_seq.sv
// mod47_horner_seq
//
// Evaluates a digit frame by Horner's rule, acc = (acc*33 + d) mod 47. One
// x33-mod-47 constant unit and one mod-47 adder are shared across the steps.
// Each digit takes three cycles: ACC (accept), MUL (p = acc*33 mod 47) and
// ADD (acc = p + d mod 47). When the frame closes, the residue waits in DONE
// until downstream accepts it.
//
// Handshake semantics (both streams): a transfer happens on a rising clk edge
// where valid and ready are both high. A producer holds valid and its payload
// steady until that edge. in_ready and out_valid are pure functions of the
// FSM state. They never depend combinationally on in_valid or out_ready.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   digit available
//   in_ready   block can accept a digit (ACC state only)
//   in_digit   6-bit digit, legal 0..46 (47..63 are folded and flagged)
//   in_last    final digit of the frame, qualified by the input handshake
//   out_valid  frame residue available (DONE state)
//   out_ready  downstream accepts the residue
//   out_res    residue register, 0..46, follows acc at all times
//   out_err    frame error flag, meaningful while out_valid is high
//   busy       high in any state except ACC with an empty digit count
//   dbg_state  FSM state: 0=ACC, 1=MUL, 2=ADD, 3=DONE
module mod47_horner_seq #(
    parameter int NDIG = 8,
    parameter int CW   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_digit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_res,
    output logic       out_err,
    output logic       busy,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_ACC  = 2'd0,
        S_MUL  = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Exact (a*33) mod 47 for a < 47. The product is below 47*64, so a
    // restoring reduction by 47<<5 down to 47<<0 leaves the remainder
    // without a divider.
    function automatic logic [5:0] mul33_mod47(input logic [5:0] a);
        logic [10:0] x;
        x = 11'(a) * 11'd33;
        for (int i = 5; i >= 0; i--) begin
            if (x >= (11'd47 << i)) begin
                x = x - (11'd47 << i);
            end
        end
        return x[5:0];
    endfunction

    // Fold an out-of-range digit (47..63) back into 0..16.
    function automatic logic [5:0] reduce47(input logic [5:0] x);
        return (x >= 6'd47) ? (x - 6'd47) : x;
    endfunction

    state_t          state_q, state_d;
    logic [5:0]      acc_q, acc_d;
    logic [5:0]      p_q, p_d;
    logic [5:0]      d_q, d_d;
    logic            last_q, last_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            in_hs;
    logic            cnt_at_max;
    logic [6:0]      sum;
    logic [6:0]      sum_sub;

    assign in_hs      = in_valid & in_ready;
    assign cnt_at_max = (cnt_q == CW'(NDIG - 1));
    assign sum        = {1'b0, p_q} + {1'b0, d_q};
    assign sum_sub    = sum - 7'd47;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACC:   if (in_hs)     state_d = S_MUL;
            S_MUL:                  state_d = S_ADD;
            S_ADD:                  state_d = last_q ? S_DONE : S_ACC;
            S_DONE:  if (out_ready) state_d = S_ACC;
            default:                state_d = S_ACC;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        in_ready  = (state_q == S_ACC);
        out_valid = (state_q == S_DONE);
        out_err   = (state_q == S_DONE) ? err_q : 1'b0;
        out_res   = acc_q;
        busy      = !((state_q == S_ACC) && (cnt_q == '0));
        dbg_state = state_q;
    end

    // ---------------- datapath ----------------
    always_comb begin
        acc_d  = acc_q;
        p_d    = p_q;
        d_d    = d_q;
        last_d = last_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        case (state_q)
            S_ACC: begin
                if (in_hs) begin
                    d_d    = reduce47(in_digit);
                    // The NDIG-th digit closes the frame even without in_last.
                    last_d = in_last | cnt_at_max;
                    cnt_d  = cnt_q + CW'(1);
                    if (in_digit >= 6'd47)       err_d = 1'b1;
                    if (cnt_at_max && !in_last)  err_d = 1'b1;
                end
            end
            S_MUL: begin
                p_d = mul33_mod47(acc_q);
            end
            S_ADD: begin
                // p and d are both < 47, so one conditional subtract is enough.
                acc_d = (sum >= 7'd47) ? sum_sub[5:0] : sum[5:0];
            end
            S_DONE: begin
                if (out_ready) begin
                    acc_d = '0;
                    cnt_d = '0;
                    err_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            p_q    <= '0;
            d_q    <= '0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            p_q    <= p_d;
            d_q    <= d_d;
            last_q <= last_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mod47_horner_seq.sv
// Bench for mod47_horner_seq. Two instances are built: one with NDIG=8 and
// one with NDIG=4 (for the truncation cases). A select signal routes in_valid
// and the observed outputs to the instance under test. The other instance
// stays idle in ACC.
module tb_mod47_horner_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sel;
    logic       in_valid;
    logic       in_last;
    logic [5:0] in_digit;
    logic       out_ready;

    logic       va, vb, ra, rb, ova, ovb, ea, eb, ba, bb;
    logic [5:0] resa, resb;
    logic [1:0] dsa, dsb;

    logic       in_ready, out_valid, out_err, busy;
    logic [5:0] out_res;
    logic [1:0] dbg;

    assign va        = in_valid & ~sel;
    assign vb        = in_valid & sel;
    assign in_ready  = sel ? rb   : ra;
    assign out_valid = sel ? ovb  : ova;
    assign out_res   = sel ? resb : resa;
    assign out_err   = sel ? eb   : ea;
    assign busy      = sel ? bb   : ba;
    assign dbg       = sel ? dsb  : dsa;

    mod47_horner_seq #(.NDIG(8), .CW(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(va), .in_ready(ra), .in_digit(in_digit),
        .in_last(in_last), .out_valid(ova), .out_ready(out_ready), .out_res(resa),
        .out_err(ea), .busy(ba), .dbg_state(dsa)
    );

    mod47_horner_seq #(.NDIG(4), .CW(8)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(vb), .in_ready(rb), .in_digit(in_digit),
        .in_last(in_last), .out_valid(ovb), .out_ready(out_ready), .out_res(resb),
        .out_err(eb), .busy(bb), .dbg_state(dsb)
    );

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;
    logic [6:0] exp_q[$];   // {err, residue}

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: Horner mod 47 written directly from the arithmetic rules.
    function automatic logic [6:0] model(input logic [7:0][5:0] dig, input int n,
                                         input bit set_last, input int maxd);
        int acc = 0;
        int err = 0;
        for (int i = 0; i < n; i++) begin
            int d = int'(dig[i]);
            if (d >= 47) err = 1;
            acc = (acc * 33 + (d % 47)) % 47;
        end
        if (n == maxd && !set_last) err = 1;
        return {err[0], acc[5:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_digit(input logic [5:0] d, input bit last, input int gap);
        int n = 0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_digit = d;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Entered at the first negedge after the last-digit handshake (cycle t+1).
    task automatic collect(input int stall, input string tag);
        int k = 1;
        logic [6:0] e;
        e = exp_q.pop_front();
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) begin
            check({tag, "_result_timeout"}, 0, 1);
            return;
        end
        check({tag, "_latency"}, k, 3);
        check({tag, "_res"}, int'(out_res), int'(e[5:0]));
        check({tag, "_err"}, int'(out_err), int'(e[6]));
        if (stall > 0) begin
            int ok = 1;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                if (!(out_valid && out_res == e[5:0] && out_err == e[6] && !in_ready))
                    ok = 0;
            end
            check({tag, "_stall_hold"}, ok, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_after_in_ready"}, int'(in_ready), 1);
        check({tag, "_after_out_valid"}, int'(out_valid), 0);
        check({tag, "_after_busy"}, int'(busy), 0);
    endtask

    task automatic run_frame(input bit s, input logic [7:0][5:0] dig, input int n,
                             input bit set_last, input int stall, input bit rgap,
                             input string tag);
        sel = s;
        for (int i = 0; i < n; i++) begin
            send_digit(dig[i], set_last && (i == n - 1),
                       rgap ? int'($urandom_range(0, 2)) : 0);
        end
        collect(stall, tag);
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        bit               sel;
        logic [7:0][5:0]  dig;
        logic [3:0]       n;
        bit               set_last;
        logic [3:0]       stall;
        logic [5:0]       exp_res;
        bit               exp_err;
    } vec_t;

    function automatic vec_t mk(input bit s, input int d0, input int d1, input int d2,
                                input int d3, input int n, input bit sl, input int st,
                                input int r, input bit e);
        vec_t v;
        v          = '0;
        v.sel      = s;
        v.dig[0]   = 6'(d0);
        v.dig[1]   = 6'(d1);
        v.dig[2]   = 6'(d2);
        v.dig[3]   = 6'(d3);
        v.n        = 4'(n);
        v.set_last = sl;
        v.stall    = 4'(st);
        v.exp_res  = 6'(r);
        v.exp_err  = e;
        return v;
    endfunction

    vec_t tbl[7];

    initial begin
        logic [7:0][5:0] rd;
        int n;
        bit sl;
        int ok;

        tbl[0] = mk(0, 1, 2, 0, 0, 2, 1, 0, 35, 0);
        tbl[1] = mk(0, 1, 2, 3, 0, 3, 1, 0, 30, 0);
        tbl[2] = mk(0, 1, 2, 3, 0, 3, 1, 5, 30, 0);
        tbl[3] = mk(0, 50, 0, 0, 0, 1, 1, 0, 3, 1);
        tbl[4] = mk(0, 46, 0, 0, 0, 1, 1, 0, 46, 0);
        tbl[5] = mk(1, 1, 1, 1, 1, 4, 0, 0, 24, 1);
        tbl[6] = mk(1, 1, 1, 1, 1, 4, 1, 0, 24, 0);

        rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_digit = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_res", int'(out_res), 0);
        check("reset_out_err", int'(out_err), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_state", int'(dbg), 0);

        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({tbl[i].exp_err, tbl[i].exp_res});
            run_frame(tbl[i].sel, tbl[i].dig, int'(tbl[i].n), tbl[i].set_last,
                      int'(tbl[i].stall), 1'b0, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a frame: digits 5, 7, then rst during MUL.
        sel = 1'b0;
        send_digit(6'd5, 1'b0, 0);
        send_digit(6'd7, 1'b0, 0);
        check("midrst_in_mul", int'(dbg), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_res", int'(out_res), 0);
        check("midrst_busy", int'(busy), 0);
        ok = 1;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) ok = 0;
            @(negedge clk);
        end
        check("midrst_no_out_valid", ok, 1);
        rd = '0;
        rd[0] = 6'd9;
        exp_q.push_back({1'b0, 6'd9});
        run_frame(0, rd, 1, 1'b1, 0, 1'b0, "midrst_fresh");

        // Random regression on the NDIG=8 instance.
        for (int f = 0; f < 40; f++) begin
            n  = int'($urandom_range(1, 8));
            rd = '0;
            for (int i = 0; i < n; i++) begin
                rd[i] = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(47, 63))
                                                    : 6'($urandom_range(0, 46));
            end
            sl = (n < 8) ? 1'b1 : bit'($urandom_range(0, 1));
            exp_q.push_back(model(rd, n, sl, 8));
            run_frame(0, rd, n, sl, int'($urandom_range(0, 3)), 1'b1,
                      $sformatf("rand%0d", f));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
